// File: rtl/shift_sequencer.sv
// Sequential 16-bit shifter: a single ternary shift stage is reused for three
// cycles, applying one base-3 digit of the shift amount per cycle.
module shift_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [3:0]       shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ST0  = 3'd1,
        S_ST1  = 3'd2,
        S_ST2  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRA = 2'b01;
    localparam logic [1:0] M_ROR = 2'b10;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_mode;
    logic [5:0]       r_digits;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       w_amt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_busy;
    logic             w_done;

    // Packed {d2,d1,d0} base-3 digits of a 0..15 shift amount.
    function automatic logic [5:0] to_digits(input logic [3:0] amt);
        logic [5:0] d;
        case (amt)
            4'd0:    d = 6'b00_00_00;
            4'd1:    d = 6'b00_00_01;
            4'd2:    d = 6'b00_00_10;
            4'd3:    d = 6'b00_01_00;
            4'd4:    d = 6'b00_01_01;
            4'd5:    d = 6'b00_01_10;
            4'd6:    d = 6'b00_10_00;
            4'd7:    d = 6'b00_10_01;
            4'd8:    d = 6'b00_10_10;
            4'd9:    d = 6'b01_00_00;
            4'd10:   d = 6'b01_00_01;
            4'd11:   d = 6'b01_00_10;
            4'd12:   d = 6'b01_01_00;
            4'd13:   d = 6'b01_01_01;
            4'd14:   d = 6'b01_01_10;
            default: d = 6'b01_10_00;
        endcase
        return d;
    endfunction

    function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] v,
                                                 input logic [3:0]       amt,
                                                 input logic [1:0]       m);
        logic signed [WIDTH-1:0] sv;
        logic [2*WIDTH-1:0]      dbl;
        logic [WIDTH-1:0]        r;
        sv  = v;
        dbl = {v, v} >> amt;
        case (m)
            M_SLL:   r = v << amt;
            M_SRA:   r = sv >>> amt;
            M_ROR:   r = dbl[WIDTH-1:0];
            default: r = v;
        endcase
        return r;
    endfunction

    // Weight of the digit consumed in the current stage: 1, 3 or 9.
    always_comb begin
        w_amt = 4'd0;
        case (r_state)
            S_ST0:   w_amt = {2'b00, r_digits[1:0]};
            S_ST1:   w_amt = {2'b00, r_digits[3:2]} * 4'd3;
            S_ST2:   w_amt = (r_digits[5:4] == 2'd1) ? 4'd9 : 4'd0;
            default: w_amt = 4'd0;
        endcase
    end

    assign w_shifted = shift_op(r_work, w_amt, r_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next = S_ST0;
            end
            S_ST0:  w_next = S_ST1;
            S_ST1:  w_next = S_ST2;
            S_ST2:  w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // The last stage's shift lands in result directly, so result is valid in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= 2'b00;
            r_digits <= 6'd0;
            r_work   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_digits <= to_digits(shamt);
                        r_work   <= data_in;
                    end
                end
                S_ST0, S_ST1: r_work <= w_shifted;
                S_ST2: begin
                    r_work   <= w_shifted;
                    r_result <= w_shifted;
                end
                default: ;
            endcase
        end
    end

    assign busy   = w_busy;
    assign done   = w_done;
    assign result = r_result;

endmodule
